// File: rtl/lcd_bus_decoder.sv
// HD44780-style 4-bit LCD bus receiver with a 2-line character mirror.
// Decodes nibble strobes into bytes and executes the driver command subset.
module lcd_bus_decoder #(
   parameter int unsigned LINE_LEN   = 16,
   parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       LCD_RS,
   input  logic       LCD_W,
   input  logic       LCD_E,
   input  logic       lcd0,
   input  logic       lcd1,
   input  logic       lcd2,
   input  logic       lcd3,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [6:0] cur_addr,
   output logic       four_bit,
   output logic       display_on,
   output logic       busy,
   output logic       cmd_valid,
   output logic [7:0] cmd_byte,
   output logic       err
);

   typedef enum logic {PH_HI, PH_LO} phase_t;

   localparam logic [6:0] L1_END  = 7'(LINE_LEN - 1);
   localparam logic [6:0] L2_BEG  = 7'h40;
   localparam logic [6:0] L2_END  = 7'(64 + LINE_LEN - 1);
   localparam logic [4:0] L2_BASE = 5'(LINE_LEN);

   logic       r_e_d;
   phase_t     r_phase;
   logic [3:0] r_hi;
   logic       r_hi_rs;
   logic       r_exec;
   logic       r_x_rs;
   logic [7:0] r_x_byte;
   logic [6:0] r_cur_addr;
   logic       r_inc;
   logic       r_four_bit;
   logic       r_disp;
   logic       r_busy;
   logic [4:0] r_fill;
   logic       r_cmd_valid;
   logic [7:0] r_cmd_byte;
   logic       r_err;
   logic [7:0] r_rd;
   logic [7:0] r_buf [0:2*LINE_LEN-1];

   logic [3:0] w_nib;
   logic       w_strobe;
   logic       w_wstb;
   logic [6:0] w_set_addr;
   logic       w_set_ok;
   logic       w_we;
   logic [4:0] w_widx;
   logic [7:0] w_wdata;

   function automatic logic [4:0] f_index(input logic [6:0] a);
      return a[6] ? 5'(a - L2_BEG) + L2_BASE : 5'(a);
   endfunction

   // Cursor walks line 1 then line 2 as one ring, in either direction.
   function automatic logic [6:0] f_step(input logic [6:0] a,
                                         input logic       inc);
      if (inc) begin
         if (a == L1_END) return L2_BEG;
         if (a == L2_END) return 7'h00;
         return a + 7'd1;
      end
      if (a == 7'h00) return L2_END;
      if (a == L2_BEG) return L1_END;
      return a - 7'd1;
   endfunction

   assign w_nib      = {lcd3, lcd2, lcd1, lcd0};
   assign w_strobe   = r_e_d & ~LCD_E;
   assign w_wstb     = w_strobe & ~LCD_W;
   assign w_set_addr = r_x_byte[6:0];
   assign w_set_ok   = (w_set_addr <= L1_END) ||
                       (w_set_addr >= L2_BEG && w_set_addr <= L2_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_e_d       <= 1'b0;
         r_phase     <= PH_HI;
         r_hi        <= 4'h0;
         r_hi_rs     <= 1'b0;
         r_exec      <= 1'b0;
         r_x_rs      <= 1'b0;
         r_x_byte    <= 8'h00;
         r_cur_addr  <= 7'h00;
         r_inc       <= 1'b1;
         r_four_bit  <= 1'b0;
         r_disp      <= 1'b0;
         r_busy      <= 1'b0;
         r_fill      <= 5'd0;
         r_cmd_valid <= 1'b0;
         r_cmd_byte  <= 8'h00;
         r_err       <= 1'b0;
      end else begin
         r_e_d       <= LCD_E;
         r_exec      <= 1'b0;
         r_cmd_valid <= 1'b0;
         if (r_busy) begin
            r_fill <= r_fill + 5'd1;
            if (r_fill == 5'd31) begin
               r_busy     <= 1'b0;
               r_cur_addr <= 7'h00;
               r_inc      <= 1'b1;
            end
         end
         if (w_wstb) begin
            if (r_busy) begin
               r_err <= 1'b1;
            end else if (!r_four_bit) begin
               if (!LCD_RS && w_nib == 4'h2) begin
                  r_four_bit <= 1'b1;
                  r_exec     <= 1'b1;
                  r_x_rs     <= 1'b0;
                  r_x_byte   <= 8'h20;
               end else if (LCD_RS || w_nib != 4'h3) begin
                  r_err <= 1'b1;
               end
            end else if (r_phase == PH_HI) begin
               r_hi    <= w_nib;
               r_hi_rs <= LCD_RS;
               r_phase <= PH_LO;
            end else begin
               r_phase <= PH_HI;
               if (LCD_RS != r_hi_rs) begin
                  r_err <= 1'b1;
               end else begin
                  r_exec   <= 1'b1;
                  r_x_rs   <= LCD_RS;
                  r_x_byte <= {r_hi, w_nib};
               end
            end
         end
         if (r_exec) begin
            if (r_x_rs) begin
               r_cur_addr <= f_step(r_cur_addr, r_inc);
            end else begin
               r_cmd_valid <= 1'b1;
               r_cmd_byte  <= r_x_byte;
               priority case (1'b1)
                  r_x_byte[7]: begin
                     if (w_set_ok) r_cur_addr <= w_set_addr;
                     else          r_err      <= 1'b1;
                  end
                  r_x_byte[6], r_x_byte[5], r_x_byte[4]: begin
                  end
                  r_x_byte[3]: r_disp     <= r_x_byte[2];
                  r_x_byte[2]: r_inc      <= r_x_byte[1];
                  r_x_byte[1]: r_cur_addr <= 7'h00;
                  r_x_byte[0]: begin
                     r_busy <= 1'b1;
                     r_fill <= 5'd0;
                  end
                  default: r_err <= 1'b1;
               endcase
            end
         end
      end
   end

   always_comb begin
      w_we    = 1'b0;
      w_widx  = r_fill;
      w_wdata = CLEAR_CHAR;
      if (r_busy) begin
         w_we = 1'b1;
      end else if (r_exec && r_x_rs) begin
         w_we    = 1'b1;
         w_widx  = f_index(r_cur_addr);
         w_wdata = r_x_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) r_buf[w_widx] <= w_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rd <= 8'h00;
      else        r_rd <= r_buf[rd_addr];
   end

   assign rd_data    = r_rd;
   assign cur_addr   = r_cur_addr;
   assign four_bit   = r_four_bit;
   assign display_on = r_disp;
   assign busy       = r_busy;
   assign cmd_valid  = r_cmd_valid;
   assign cmd_byte   = r_cmd_byte;
   assign err        = r_err;

endmodule

// File: doc/lcd_bus_decoder.md
Name: lcd_bus_decoder

Overview:
- Display-side receiver for the HD44780-style 4-bit LCD bus driven by the team's LCD write FSMs.
- Decodes the RS/W/E/data nibble stream, including the 8-bit-mode reset sequence, into bytes, and executes the command subset the drivers emit.
- Mirrors the 2x16 character display into an internal buffer with a read port.
- Used as an on-chip loopback checker and as a synthesizable display model in benches.

Parameters:
- LINE_LEN, 16, characters per line; the buffer holds 2*LINE_LEN entries.
- CLEAR_CHAR, 8'h20, value written to every buffer entry by Clear Display.

Ports:
- clk  input  1  system clock; all bus inputs are synchronous to it.
- rst_n  input  1  asynchronous active-low reset.
- LCD_RS  input  1  register select: 0 = command, 1 = data.
- LCD_W  input  1  read/write: 1 = read cycle, ignored.
- LCD_E  input  1  enable strobe; the bus is latched on its falling edge.
- lcd0, lcd1, lcd2, lcd3  input  1 each  data nibble, with lcd3 as MSB.
- rd_addr  input  5  buffer read index: 0-15 is line 1, 16-31 is line 2.
- rd_data  output  8  buffer[rd_addr], registered, 1-cycle latency.
- cur_addr  output  7  current DDRAM address (0x00-0x0F or 0x40-0x4F).
- four_bit  output  1  interface is in 4-bit mode.
- display_on  output  1  D bit from the last Display Control command.
- busy  output  1  high while a Clear Display fill is in progress.
- cmd_valid  output  1  one-cycle pulse when a command byte completes.
- cmd_byte  output  8  last completed command byte, held until the next one.
- err  output  1  sticky protocol error flag; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - four_bit=0, display_on=0, busy=0, cmd_valid=0, cmd_byte=0, err=0, cur_addr=0, rd_data=0.
  - Nibble phase = HI, increment mode (I/D=1).
  - Buffer contents are undefined; benches clear the display before checking them.
- Strobe detection:
  - e_d is registered LCD_E.
  - A strobe is e_d=1 and LCD_E=0. The bus value {LCD_RS, LCD_W, lcd3..lcd0} is sampled in that same cycle.
- Read strobes (LCD_W=1): no state change, nibble phase unchanged.
- Strobe while busy: the strobe is dropped and err is set.
- 8-bit mode (four_bit=0):
  - Each write strobe is one command whose nibble is the upper 4 bits.
  - RS=0 with nibble 0x3: no effect.
  - RS=0 with nibble 0x2: four_bit becomes 1, cmd_valid pulses with cmd_byte=8'h20.
  - Any other strobe: err is set.
- 4-bit mode, state machine HI -> LO -> HI:
  - HI: store the nibble and its RS, go to LO.
  - LO: assemble the byte {hi,lo}, go to HI.
  - If RS differs between the two halves: discard the byte, set err, go to HI.
  - The completed byte executes in the cycle after the LO strobe.
- Commands (RS=0), matched highest set bit first:
  - 1xxxxxxx, Set DDRAM:
    - a = byte[6:0].
    - 0x00-0x0F maps to index a; 0x40-0x4F maps to index LINE_LEN + (a-0x40).
    - Any other address: err set, cur_addr unchanged.
  - 001xxxxx, Function Set: accepted, no effect.
  - 00001Dxx, Display Control: display_on = D.
  - 000001Ix, Entry Mode: I/D = I.
  - 0000001x, Return Home: cur_addr = 0.
  - 00000001, Clear Display:
    - busy = 1; a 5-bit fill counter writes CLEAR_CHAR to indices 0..31, one per cycle.
    - busy drops in the cycle after index 31 is written; cur_addr = 0, I/D = 1.
  - 0x00: err set.
  - Every command pulses cmd_valid, including the error cases.
- Data (RS=1):
  - buffer[index(cur_addr)] = byte.
  - Then cur_addr steps by +1 (I/D=1) or -1 (I/D=0), wrapping 0x0F<->0x40, 0x4F<->0x00 and 0x4F->0x00 (inc), 0x00->0x4F and 0x40->0x0F (dec).
- Read port vs. write: if rd_addr matches an index written in the same cycle, rd_data returns the old value (read-before-write).
- Reset mid-byte or mid-clear: everything returns to reset values; the fill is abandoned.

Test Plan:
- Init sequence: strobes 3,3,3,2 then pairs 2/8, 0/6, 0/C, 0/1, 8/0 -> four_bit=1 after the 4th strobe; display_on=1; busy high for exactly 32 cycles; all 32 entries read 8'h20; cur_addr=0x00; err=0.
- Write "HELLO" (RS=1) after init -> rd_addr 0..4 return 48,45,4C,4C,4F; cur_addr=0x05.
- Command 0xC0, then 16 characters 'A'..'P' -> indices 16..31 hold 41..50; cur_addr wraps to 0x00.
- Entry mode 0x04, Set DDRAM 0x40, write 'Z' -> index 16=5A; cur_addr=0x0F.
- Errors:
  - HI nibble with RS=1 then LO nibble with RS=0 -> err=1, buffer unchanged.
  - Set DDRAM 0x20 -> err=1, cur_addr unchanged.
  - Strobe during clear -> err=1.
- Read strobes (W=1) interleaved between HI and LO nibbles -> byte still assembles correctly. Assert rst_n mid-clear -> busy=0 and four_bit=0 immediately.
